// File: rtl/ysyx_22050133_axi_sram_bridge.sv
// ysyx_22050133_axi_sram_bridge
// AXI4 slave that maps one address window onto a single-port synchronous SRAM
// macro with S011HD1P-style pins (active-low CEN/WEN, per-bit active-low BWEN,
// one-cycle read latency). One transaction is in flight at a time; INCR, FIXED
// and narrow transfers are always supported.
// Optional feature macro: YSYX_22050133_SRAM_BRIDGE_WRAP_EN enables WRAP bursts;
// without it a WRAP burst runs to completion with SLVERR and no SRAM access.
`timescale 1ns/1ps
module ysyx_22050133_axi_sram_bridge #(
  parameter int unsigned           DATA_WIDTH = 64,
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           ID_WIDTH   = 4,
  parameter int unsigned           SRAM_AW    = 6,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000
) (
  input  logic                    clk,
  input  logic                    rst,
  // write address channel
  output logic                    axi_aw_ready_o,
  input  logic                    axi_aw_valid_i,
  input  logic [ID_WIDTH-1:0]     axi_aw_id_i,
  input  logic [ADDR_WIDTH-1:0]   axi_aw_addr_i,
  input  logic [7:0]              axi_aw_len_i,
  input  logic [2:0]              axi_aw_size_i,
  input  logic [1:0]              axi_aw_burst_i,
  // write data channel
  output logic                    axi_w_ready_o,
  input  logic                    axi_w_valid_i,
  input  logic [DATA_WIDTH-1:0]   axi_w_data_i,
  input  logic [DATA_WIDTH/8-1:0] axi_w_strb_i,
  input  logic                    axi_w_last_i,
  // write response channel
  input  logic                    axi_b_ready_i,
  output logic                    axi_b_valid_o,
  output logic [ID_WIDTH-1:0]     axi_b_id_o,
  output logic [1:0]              axi_b_resp_o,
  // read address channel
  output logic                    axi_ar_ready_o,
  input  logic                    axi_ar_valid_i,
  input  logic [ID_WIDTH-1:0]     axi_ar_id_i,
  input  logic [ADDR_WIDTH-1:0]   axi_ar_addr_i,
  input  logic [7:0]              axi_ar_len_i,
  input  logic [2:0]              axi_ar_size_i,
  input  logic [1:0]              axi_ar_burst_i,
  // read data channel
  input  logic                    axi_r_ready_i,
  output logic                    axi_r_valid_o,
  output logic [ID_WIDTH-1:0]     axi_r_id_o,
  output logic [1:0]              axi_r_resp_o,
  output logic [DATA_WIDTH-1:0]   axi_r_data_o,
  output logic                    axi_r_last_o,
  // SRAM macro
  output logic [SRAM_AW-1:0]      sram_a,
  output logic                    sram_cen,
  output logic                    sram_wen,
  output logic [DATA_WIDTH-1:0]   sram_bwen,
  output logic [DATA_WIDTH-1:0]   sram_d,
  input  logic [DATA_WIDTH-1:0]   sram_q
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned OFF        = $clog2(STRB_WIDTH);
  localparam int unsigned WIN_LSB    = SRAM_AW + OFF;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic GRANT_READ  = 1'b0;
  localparam logic GRANT_WRITE = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_DATA,
    S_WR_RESP,
    S_RD_REQ,
    S_RD_DATA
  } state_e;

  state_e                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic [2:0]            size_q, size_d;
  logic [1:0]            burst_q, burst_d;
  logic                  err_q, err_d;
  logic [7:0]            beat_q, beat_d;

  logic                  aw_grant;
  logic                  ar_grant;
  logic [SRAM_AW-1:0]    word_idx;

  // Address of the beat after the current one, for any burst type.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(
    input logic [ADDR_WIDTH-1:0] addr,
    input logic [7:0]            len,
    input logic [2:0]            size,
    input logic [1:0]            burst
  );
    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] incr;
    logic [ADDR_WIDTH-1:0] wrap_mask;
    step      = ADDR_WIDTH'(1) << size;
    incr      = addr + step;
    wrap_mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
    next_addr = incr;
    case (burst)
      BURST_FIXED: next_addr = addr;
`ifdef YSYX_22050133_SRAM_BRIDGE_WRAP_EN
      // The block of (len+1)<<size bytes is aligned, so only the in-block
      // offset bits advance and carry out of the block is dropped.
      BURST_WRAP:  next_addr = (addr & ~wrap_mask) | (incr & wrap_mask);
`endif
      default:     next_addr = incr;
    endcase
  endfunction

  // Error status decided once, when the address handshake is accepted.
  function automatic logic req_err(
    input logic [ADDR_WIDTH-1:0] addr,
    input logic [7:0]            len,
    input logic [2:0]            size,
    input logic [1:0]            burst
  );
    logic err;
    err = (addr[ADDR_WIDTH-1:WIN_LSB] != BASE_ADDR[ADDR_WIDTH-1:WIN_LSB]);
    if (size > 3'(OFF)) err = 1'b1;
`ifdef YSYX_22050133_SRAM_BRIDGE_WRAP_EN
    if (burst == BURST_WRAP &&
        !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) err = 1'b1;
`else
    if (burst == BURST_WRAP) err = 1'b1;
`endif
    return err;
  endfunction

  assign word_idx = addr_q[WIN_LSB-1:OFF];

  // State and transaction-context registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= GRANT_READ;
      id_q         <= '0;
      addr_q       <= '0;
      len_q        <= '0;
      size_q       <= '0;
      burst_q      <= '0;
      err_q        <= 1'b0;
      beat_q       <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge value of the others, independent of statement order.
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      size_q       <= size_d;
      burst_q      <= burst_d;
      err_q        <= err_d;
      beat_q       <= beat_d;
    end
  end

  // Next-state logic, AXI handshakes and SRAM pin drive.
  always_comb begin
    // NOTE: every signal written below gets a value here first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    id_d           = id_q;
    addr_d         = addr_q;
    len_d          = len_q;
    size_d         = size_q;
    burst_d        = burst_q;
    err_d          = err_q;
    beat_d         = beat_q;

    aw_grant       = 1'b0;
    ar_grant       = 1'b0;

    axi_aw_ready_o = 1'b0;
    axi_w_ready_o  = 1'b0;
    axi_b_valid_o  = 1'b0;
    axi_b_id_o     = '0;
    axi_b_resp_o   = RESP_OKAY;
    axi_ar_ready_o = 1'b0;
    axi_r_valid_o  = 1'b0;
    axi_r_id_o     = '0;
    axi_r_resp_o   = RESP_OKAY;
    axi_r_data_o   = '0;
    axi_r_last_o   = 1'b0;

    sram_a         = '0;
    sram_cen       = 1'b1;
    sram_wen       = 1'b1;
    sram_bwen      = '1;
    sram_d         = '0;

    // Reset is synchronous; holding outputs idle while it is asserted keeps an
    // abandoned burst from touching the SRAM or handshaking in that cycle.
    if (!rst) begin
      case (state_q)
        S_IDLE: begin
          aw_grant       = axi_aw_valid_i &&
                           (!axi_ar_valid_i || last_grant_q == GRANT_READ);
          ar_grant       = axi_ar_valid_i && !aw_grant;
          axi_aw_ready_o = aw_grant;
          axi_ar_ready_o = ar_grant;
          beat_d         = '0;
          if (aw_grant) begin
            id_d         = axi_aw_id_i;
            addr_d       = axi_aw_addr_i;
            len_d        = axi_aw_len_i;
            size_d       = axi_aw_size_i;
            burst_d      = axi_aw_burst_i;
            err_d        = req_err(axi_aw_addr_i, axi_aw_len_i, axi_aw_size_i, axi_aw_burst_i);
            last_grant_d = GRANT_WRITE;
            state_d      = S_WR_DATA;
          end else if (ar_grant) begin
            id_d         = axi_ar_id_i;
            addr_d       = axi_ar_addr_i;
            len_d        = axi_ar_len_i;
            size_d       = axi_ar_size_i;
            burst_d      = axi_ar_burst_i;
            err_d        = req_err(axi_ar_addr_i, axi_ar_len_i, axi_ar_size_i, axi_ar_burst_i);
            last_grant_d = GRANT_READ;
            state_d      = S_RD_REQ;
          end
        end

        S_WR_DATA: begin
          axi_w_ready_o = 1'b1;
          if (axi_w_valid_i) begin
            if (!err_q) begin
              sram_cen = 1'b0;
              sram_wen = 1'b0;
              sram_a   = word_idx;
              sram_d   = axi_w_data_i;
              for (int b = 0; b < STRB_WIDTH; b++) begin
                sram_bwen[8*b +: 8] = {8{~axi_w_strb_i[b]}};
              end
            end
            // A burst that ends early or runs long is reported, not truncated.
            if (axi_w_last_i != (beat_q == len_q)) err_d = 1'b1;
            beat_d = beat_q + 8'd1;
            addr_d = next_addr(addr_q, len_q, size_q, burst_q);
            if (axi_w_last_i) state_d = S_WR_RESP;
          end
        end

        S_WR_RESP: begin
          axi_b_valid_o = 1'b1;
          axi_b_id_o    = id_q;
          axi_b_resp_o  = err_q ? RESP_SLVERR : RESP_OKAY;
          if (axi_b_ready_i) state_d = S_IDLE;
        end

        S_RD_REQ: begin
          if (!err_q) begin
            sram_cen = 1'b0;
            sram_a   = word_idx;
          end
          state_d = S_RD_DATA;
        end

        S_RD_DATA: begin
          // CEN stays high here, so the macro holds sram_q through any stall.
          axi_r_valid_o = 1'b1;
          axi_r_id_o    = id_q;
          axi_r_resp_o  = err_q ? RESP_SLVERR : RESP_OKAY;
          axi_r_data_o  = err_q ? '0 : sram_q;
          axi_r_last_o  = (beat_q == len_q);
          if (axi_r_ready_i) begin
            if (beat_q == len_q) begin
              state_d = S_IDLE;
            end else begin
              beat_d  = beat_q + 8'd1;
              addr_d  = next_addr(addr_q, len_q, size_q, burst_q);
              state_d = S_RD_REQ;
            end
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22050133_axi_sram_bridge.sv
// Scoreboard bench for ysyx_22050133_axi_sram_bridge: drivers push expected
// B/R responses into queues; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_ysyx_22050133_axi_sram_bridge;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] OKAY        = 2'b00;
  localparam logic [1:0] SLVERR      = 2'b10;

  localparam logic [63:0] D1 = 64'h1122_3344_5566_7788;
  localparam logic [63:0] B0 = 64'h1010_1010_1010_1010;
  localparam logic [63:0] B1 = 64'h1111_1111_1111_1111;
  localparam logic [63:0] B2 = 64'h1212_1212_1212_1212;
  localparam logic [63:0] B3 = 64'h1313_1313_1313_1313;
  localparam logic [63:0] B2_MERGED = 64'h0000_0000_1212_1212;
  localparam logic [63:0] E0 = 64'hE0E0_E0E0_E0E0_E0E0;
  localparam logic [63:0] E1 = 64'hE1E1_E1E1_E1E1_E1E1;
  localparam logic [63:0] E2 = 64'hE2E2_E2E2_E2E2_E2E2;
  localparam logic [63:0] DX = 64'hCAFE_F00D_0000_0004;
  localparam logic [63:0] DY = 64'h0BAD_BEEF_0000_0005;

  logic        clk, rst;
  logic        axi_aw_ready_o, axi_aw_valid_i;
  logic [3:0]  axi_aw_id_i;
  logic [31:0] axi_aw_addr_i;
  logic [7:0]  axi_aw_len_i;
  logic [2:0]  axi_aw_size_i;
  logic [1:0]  axi_aw_burst_i;
  logic        axi_w_ready_o, axi_w_valid_i, axi_w_last_i;
  logic [63:0] axi_w_data_i;
  logic [7:0]  axi_w_strb_i;
  logic        axi_b_ready_i, axi_b_valid_o;
  logic [3:0]  axi_b_id_o;
  logic [1:0]  axi_b_resp_o;
  logic        axi_ar_ready_o, axi_ar_valid_i;
  logic [3:0]  axi_ar_id_i;
  logic [31:0] axi_ar_addr_i;
  logic [7:0]  axi_ar_len_i;
  logic [2:0]  axi_ar_size_i;
  logic [1:0]  axi_ar_burst_i;
  logic        axi_r_ready_i, axi_r_valid_o, axi_r_last_o;
  logic [3:0]  axi_r_id_o;
  logic [1:0]  axi_r_resp_o;
  logic [63:0] axi_r_data_o;
  logic [5:0]  sram_a;
  logic        sram_cen, sram_wen;
  logic [63:0] sram_bwen, sram_d, sram_q;

  ysyx_22050133_axi_sram_bridge dut (
    .clk(clk), .rst(rst),
    .axi_aw_ready_o(axi_aw_ready_o), .axi_aw_valid_i(axi_aw_valid_i), .axi_aw_id_i(axi_aw_id_i),
    .axi_aw_addr_i(axi_aw_addr_i), .axi_aw_len_i(axi_aw_len_i), .axi_aw_size_i(axi_aw_size_i),
    .axi_aw_burst_i(axi_aw_burst_i),
    .axi_w_ready_o(axi_w_ready_o), .axi_w_valid_i(axi_w_valid_i), .axi_w_data_i(axi_w_data_i),
    .axi_w_strb_i(axi_w_strb_i), .axi_w_last_i(axi_w_last_i),
    .axi_b_ready_i(axi_b_ready_i), .axi_b_valid_o(axi_b_valid_o), .axi_b_id_o(axi_b_id_o),
    .axi_b_resp_o(axi_b_resp_o),
    .axi_ar_ready_o(axi_ar_ready_o), .axi_ar_valid_i(axi_ar_valid_i), .axi_ar_id_i(axi_ar_id_i),
    .axi_ar_addr_i(axi_ar_addr_i), .axi_ar_len_i(axi_ar_len_i), .axi_ar_size_i(axi_ar_size_i),
    .axi_ar_burst_i(axi_ar_burst_i),
    .axi_r_ready_i(axi_r_ready_i), .axi_r_valid_o(axi_r_valid_o), .axi_r_id_o(axi_r_id_o),
    .axi_r_resp_o(axi_r_resp_o), .axi_r_data_o(axi_r_data_o), .axi_r_last_o(axi_r_last_o),
    .sram_a(sram_a), .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_bwen(sram_bwen),
    .sram_d(sram_d), .sram_q(sram_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- SRAM macro model ----------------
  logic [63:0] mem [64];
  logic        mem_clr;
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
      sram_q <= '0;
    end else if (!sram_cen) begin
      if (!sram_wen) mem[sram_a] <= (mem[sram_a] & sram_bwen) | (sram_d & ~sram_bwen);
      else           sram_q      <= mem[sram_a];
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct { logic [3:0] id; logic [1:0] resp; } b_exp_t;
  typedef struct { logic [3:0] id; logic [63:0] data; logic [1:0] resp; logic last; } r_exp_t;

  b_exp_t     exp_b[$];
  r_exp_t     exp_r[$];
  logic [5:0] acc_q[$];   // SRAM word addresses accessed
  logic       grant_q[$]; // 1 = AW granted, 0 = AR granted
  int         n_vec = 0;
  int         n_err = 0;
  int         r_cnt = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  b_exp_t eb;
  r_exp_t er;
  always @(negedge clk) begin
    if (!sram_cen) acc_q.push_back(sram_a);
    if (axi_aw_valid_i && axi_aw_ready_o) grant_q.push_back(1'b1);
    if (axi_ar_valid_i && axi_ar_ready_o) grant_q.push_back(1'b0);
    if (axi_b_valid_o && axi_b_ready_i) begin
      check("b_expected", exp_b.size() > 0, 1'b1);
      if (exp_b.size() > 0) begin
        eb = exp_b.pop_front();
        check("bid", axi_b_id_o, eb.id);
        check("bresp", axi_b_resp_o, eb.resp);
      end
    end
    if (axi_r_valid_o && axi_r_ready_i) begin
      r_cnt++;
      check("r_expected", exp_r.size() > 0, 1'b1);
      if (exp_r.size() > 0) begin
        er = exp_r.pop_front();
        check("rid", axi_r_id_o, er.id);
        check("rresp", axi_r_resp_o, er.resp);
        check("rdata", axi_r_data_o, er.data);
        check("rlast", axi_r_last_o, er.last);
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic aw_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int c = 0;
    axi_aw_valid_i = 1'b1; axi_aw_id_i = id; axi_aw_addr_i = addr;
    axi_aw_len_i = len; axi_aw_size_i = size; axi_aw_burst_i = burst;
    do begin @(negedge clk); c++; end while (!axi_aw_ready_o && c < 200);
    check("aw_handshake", axi_aw_ready_o, 1'b1);
    @(posedge clk); #1;
    axi_aw_valid_i = 1'b0;
  endtask

  task automatic ar_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int c = 0;
    axi_ar_valid_i = 1'b1; axi_ar_id_i = id; axi_ar_addr_i = addr;
    axi_ar_len_i = len; axi_ar_size_i = size; axi_ar_burst_i = burst;
    do begin @(negedge clk); c++; end while (!axi_ar_ready_o && c < 200);
    check("ar_handshake", axi_ar_ready_o, 1'b1);
    @(posedge clk); #1;
    axi_ar_valid_i = 1'b0;
  endtask

  task automatic w_beat(input logic [63:0] data, input logic [7:0] strb, input logic last);
    int c = 0;
    axi_w_valid_i = 1'b1; axi_w_data_i = data; axi_w_strb_i = strb; axi_w_last_i = last;
    do begin @(negedge clk); c++; end while (!axi_w_ready_o && c < 200);
    check("w_handshake", axi_w_ready_o, 1'b1);
    @(posedge clk); #1;
    axi_w_valid_i = 1'b0; axi_w_last_i = 1'b0;
  endtask

  task automatic drain();
    int c = 0;
    while ((exp_b.size() != 0 || exp_r.size() != 0) && c < 500) begin @(negedge clk); c++; end
    check("drain_pending", exp_b.size() + exp_r.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_hs"}, {axi_aw_ready_o, axi_w_ready_o, axi_b_valid_o, axi_ar_ready_o, axi_r_valid_o}, 5'b0);
    check({tag, "_bresp"}, {axi_b_id_o, axi_b_resp_o}, 6'b0);
    check({tag, "_rmeta"}, {axi_r_id_o, axi_r_resp_o, axi_r_last_o}, 7'b0);
    check({tag, "_rdata"}, axi_r_data_o, 64'b0);
    check({tag, "_sram_ctl"}, {sram_cen, sram_wen, sram_a}, {1'b1, 1'b1, 6'b0});
    check({tag, "_sram_bwen"}, sram_bwen, {64{1'b1}});
    check({tag, "_sram_d"}, sram_d, 64'b0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    n_vec++; n_err++;
    $display("FAIL watchdog: simulation did not complete, got timeout expected done");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // ---------------- directed sequence ----------------
  logic [5:0] exp_wrap[4];
  initial begin
    rst = 1'b1; mem_clr = 1'b1;
    axi_aw_valid_i = 0; axi_aw_id_i = 0; axi_aw_addr_i = 0; axi_aw_len_i = 0;
    axi_aw_size_i = 0; axi_aw_burst_i = 0;
    axi_w_valid_i = 0; axi_w_data_i = 0; axi_w_strb_i = 0; axi_w_last_i = 0;
    axi_ar_valid_i = 0; axi_ar_id_i = 0; axi_ar_addr_i = 0; axi_ar_len_i = 0;
    axi_ar_size_i = 0; axi_ar_burst_i = 0;
    axi_b_ready_i = 1'b1; axi_r_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0; mem_clr = 1'b0;

    // 1: single-beat write then read-back with latency check
    acc_q.delete();
    exp_b.push_back('{id: 4'd1, resp: OKAY});
    aw_send(4'd1, 32'h8000_0008, 8'd0, 3'd3, BURST_INCR);
    w_beat(D1, 8'hFF, 1'b1);
    drain();
    check("wr1_access_count", acc_q.size(), 1);
    if (acc_q.size() > 0) check("wr1_sram_a", acc_q[0], 6'd1);
    exp_r.push_back('{id: 4'd2, data: D1, resp: OKAY, last: 1'b1});
    ar_send(4'd2, 32'h8000_0008, 8'd0, 3'd3, BURST_INCR);
    @(negedge clk);
    check("rd1_t1_access", {axi_r_valid_o, sram_cen, sram_wen, sram_a}, {1'b0, 1'b0, 1'b1, 6'd1});
    @(negedge clk);
    check("rd1_t2_rvalid", axi_r_valid_o, 1'b1);
    drain();

    // 2: 4-beat INCR write, third beat with low-half strobes only
    exp_b.push_back('{id: 4'd3, resp: OKAY});
    aw_send(4'd3, 32'h8000_0000, 8'd3, 3'd3, BURST_INCR);
    w_beat(B0, 8'hFF, 1'b0);
    w_beat(B1, 8'hFF, 1'b0);
    w_beat(B2, 8'h0F, 1'b0);
    w_beat(B3, 8'hFF, 1'b1);
    drain();
    exp_r.push_back('{id: 4'd4, data: B0, resp: OKAY, last: 1'b0});
    exp_r.push_back('{id: 4'd4, data: B1, resp: OKAY, last: 1'b0});
    exp_r.push_back('{id: 4'd4, data: B2_MERGED, resp: OKAY, last: 1'b0});
    exp_r.push_back('{id: 4'd4, data: B3, resp: OKAY, last: 1'b1});
    ar_send(4'd4, 32'h8000_0000, 8'd3, 3'd3, BURST_INCR);
    drain();

    // 3: WRAP read len 3 from word 3
    acc_q.delete();
`ifdef YSYX_22050133_SRAM_BRIDGE_WRAP_EN
    exp_r.push_back('{id: 4'd5, data: B3, resp: OKAY, last: 1'b0});
    exp_r.push_back('{id: 4'd5, data: B0, resp: OKAY, last: 1'b0});
    exp_r.push_back('{id: 4'd5, data: B1, resp: OKAY, last: 1'b0});
    exp_r.push_back('{id: 4'd5, data: B2_MERGED, resp: OKAY, last: 1'b1});
    ar_send(4'd5, 32'h8000_0018, 8'd3, 3'd3, BURST_WRAP);
    drain();
    exp_wrap[0] = 6'd3; exp_wrap[1] = 6'd0; exp_wrap[2] = 6'd1; exp_wrap[3] = 6'd2;
    check("wrap_access_count", acc_q.size(), 4);
    for (int i = 0; i < 4; i++) if (i < acc_q.size()) check("wrap_sram_a", acc_q[i], exp_wrap[i]);
`else
    for (int i = 0; i < 4; i++)
      exp_r.push_back('{id: 4'd5, data: 64'd0, resp: SLVERR, last: (i == 3)});
    ar_send(4'd5, 32'h8000_0018, 8'd3, 3'd3, BURST_WRAP);
    drain();
    check("wrap_disabled_no_access", acc_q.size(), 0);
`endif

    // 4: out-of-window read and write
    acc_q.delete();
    exp_r.push_back('{id: 4'd6, data: 64'd0, resp: SLVERR, last: 1'b1});
    ar_send(4'd6, 32'h0000_1000, 8'd0, 3'd3, BURST_INCR);
    drain();
    exp_b.push_back('{id: 4'd7, resp: SLVERR});
    aw_send(4'd7, 32'h0000_1000, 8'd0, 3'd3, BURST_INCR);
    w_beat(64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, 1'b1);
    drain();
    check("oow_no_access", acc_q.size(), 0);

    // 5: reset during the third beat of a 4-beat write to words 8..11
    aw_send(4'd8, 32'h8000_0040, 8'd3, 3'd3, BURST_INCR);
    w_beat(E0, 8'hFF, 1'b0);
    w_beat(E1, 8'hFF, 1'b0);
    axi_w_valid_i = 1'b1; axi_w_data_i = E2; axi_w_strb_i = 8'hFF; axi_w_last_i = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("rst_cycle_cen", sram_cen, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0; axi_w_valid_i = 1'b0;
    @(negedge clk);
    check_reset_outputs("post_rst");
    @(posedge clk); #1;

    // 6: simultaneous AW/AR (write first, then read), with an rready stall
    grant_q.delete();
    exp_b.push_back('{id: 4'd9, resp: OKAY});
    exp_b.push_back('{id: 4'd11, resp: OKAY});
    exp_r.push_back('{id: 4'd10, data: E0, resp: OKAY, last: 1'b0});
    exp_r.push_back('{id: 4'd10, data: E1, resp: OKAY, last: 1'b0});
    exp_r.push_back('{id: 4'd10, data: 64'd0, resp: OKAY, last: 1'b0});
    exp_r.push_back('{id: 4'd10, data: 64'd0, resp: OKAY, last: 1'b1});
    fork
      begin : wr_agent
        aw_send(4'd9, 32'h8000_0020, 8'd0, 3'd3, BURST_INCR);
        w_beat(DX, 8'hFF, 1'b1);
        aw_send(4'd11, 32'h8000_0028, 8'd0, 3'd3, BURST_INCR);
        w_beat(DY, 8'hFF, 1'b1);
      end
      begin : rd_agent
        int base, c;
        logic [70:0] snap;
        base = r_cnt;
        c = 0;
        ar_send(4'd10, 32'h8000_0040, 8'd3, 3'd3, BURST_INCR);
        while (!(axi_r_valid_o && r_cnt == base + 1) && c < 200) begin
          @(posedge clk); #1; c++;
        end
        check("stall_reached", axi_r_valid_o, 1'b1);
        axi_r_ready_i = 1'b0;
        snap = {axi_r_id_o, axi_r_resp_o, axi_r_last_o, axi_r_data_o};
        repeat (3) begin
          @(negedge clk);
          check("stall_hold", {axi_r_valid_o, axi_r_id_o, axi_r_resp_o, axi_r_last_o, axi_r_data_o},
                {1'b1, snap});
        end
        @(posedge clk); #1;
        axi_r_ready_i = 1'b1;
      end
    join
    drain();
    check("grant_count", grant_q.size(), 3);
    if (grant_q.size() == 3) check("grant_order", {grant_q[0], grant_q[1], grant_q[2]}, 3'b101);

    // 7: read back both contended writes
    exp_r.push_back('{id: 4'd12, data: DX, resp: OKAY, last: 1'b0});
    exp_r.push_back('{id: 4'd12, data: DY, resp: OKAY, last: 1'b1});
    ar_send(4'd12, 32'h8000_0020, 8'd1, 3'd3, BURST_INCR);
    drain();

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
